// File: rtl/cpu_types_pkg.sv
// Shared CPU types.
// Contents:
//   word_t        32-bit datapath word
//   NOP_INSTR     bubble instruction (addi x0,x0,0)
//   fetch_state_t fetch-stage FSM states
//   ifid_t        IF/ID pipeline latch contents
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam word_t NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
        word_t pc4;
        logic  valid;
    } ifid_t;

endpackage

// File: rtl/ifid_latch.sv
// IF/ID pipeline register with write enable and flush-to-bubble.
// A flush wins over the write enable, so a squash always lands even while the latch is held.
// Ports:
//   CLK   in   clock, rising edge
//   nRST  in   asynchronous active-low reset (loads the bubble)
//   we    in   capture d this cycle
//   flush in   overwrite contents with the bubble
//   d     in   next IF/ID contents
//   q     out  current IF/ID contents
module ifid_latch
    import cpu_types_pkg::*;
#(
    parameter word_t BUBBLE_INSTR = NOP_INSTR
) (
    input  logic  CLK,
    input  logic  nRST,
    input  logic  we,
    input  logic  flush,
    input  ifid_t d,
    output ifid_t q
);

    localparam ifid_t BUBBLE = '{instr: BUBBLE_INSTR, pc: '0, pc4: '0, valid: 1'b0};

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues icache reads and fills the IF/ID latch.
// Priority each cycle: flush > stall (IFID_write/PC_write low) > normal advance.
// Optional feature: define FETCH_STATS_EN to add the stall_cnt/squash_cnt counter outputs.
// Ports:
//   CLK, nRST             clock, asynchronous active-low reset
//   flush, redirect_pc    squash IF/ID and redirect PC (target low bits forced to 00)
//   IFID_write, PC_write  hazard-unit enables (0 = hold)
//   halt                  stop issuing new fetches, sticky until reset
//   ihit, imemload        icache response
//   iREN, imemaddr        icache request
//   imemload_id, pc_id, pc4_id, valid_id   IF/ID latch contents
//   stall_cnt, squash_cnt (FETCH_STATS_EN only) saturating event counters
module fetch_stage #(
    parameter logic [31:0] PC_INIT   = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        flush,
    input  logic [31:0] redirect_pc,
    input  logic        IFID_write,
    input  logic        PC_write,
    input  logic        halt,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] imemaddr,
    output logic [31:0] imemload_id,
    output logic [31:0] pc_id,
    output logic [31:0] pc4_id,
    output logic        valid_id
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] squash_cnt
`endif
);

    import cpu_types_pkg::*;

    fetch_state_t state_q, state_d;
    word_t        pc_q, pc_d;
    word_t        redir_q, redir_d;
    word_t        hold_q, hold_d;
    logic         halted_q;
    logic         started_q;  // keeps iREN low until the first clock after reset

    word_t pc_plus4;
    word_t target;
    logic  req;
    logic  hit;
    logic  advance;
    logic  ifid_we;
    ifid_t ifid_d;
    ifid_t ifid_q;

    assign pc_plus4 = pc_q + 32'd4;
    assign target   = {redirect_pc[31:2], 2'b00};
    assign req      = started_q && !halted_q;
    assign hit      = ihit && req;
    assign advance  = IFID_write && PC_write;
    assign imemaddr = pc_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= FETCH;
            pc_q      <= PC_INIT;
            redir_q   <= '0;
            hold_q    <= '0;
            halted_q  <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            redir_q   <= redir_d;
            hold_q    <= hold_d;
            halted_q  <= halted_q || halt;
            started_q <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        redir_d = redir_q;
        hold_d  = hold_q;
        iREN    = 1'b0;
        ifid_we = 1'b0;
        ifid_d  = '{instr: imemload, pc: pc_q, pc4: pc_plus4, valid: 1'b1};

        case (state_q)
            FETCH: begin
                iREN = req;
                if (flush) begin
                    if (hit || !req) begin
                        pc_d = target;
                    end else begin
                        // Request is still outstanding; wait for it before redirecting.
                        redir_d = target;
                        state_d = DRAIN;
                    end
                end else if (hit) begin
                    if (advance) begin
                        ifid_we = 1'b1;
                        pc_d    = pc_plus4;
                    end else begin
                        hold_d  = imemload;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_d    = target;
                    state_d = FETCH;
                end else if (advance) begin
                    ifid_we      = 1'b1;
                    ifid_d.instr = hold_q;
                    pc_d         = pc_plus4;
                    state_d      = FETCH;
                end
            end
            DRAIN: begin
                iREN = 1'b1;
                if (flush) begin
                    redir_d = target;
                end
                if (ihit) begin
                    pc_d    = flush ? target : redir_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    ifid_latch #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_ifid (
        .CLK   (CLK),
        .nRST  (nRST),
        .we    (ifid_we),
        .flush (flush),
        .d     (ifid_d),
        .q     (ifid_q)
    );

    assign imemload_id = ifid_q.instr;
    assign pc_id       = ifid_q.pc;
    assign pc4_id      = ifid_q.pc4;
    assign valid_id    = ifid_q.valid;

`ifdef FETCH_STATS_EN
    logic stall_ev;
    logic squash_ev;

    assign stall_ev  = (state_q == HOLD) || !PC_write;
    // A flush discards a fetch when a request is live in FETCH or a word sits in HOLD.
    assign squash_ev = flush && (((state_q == FETCH) && req) || (state_q == HOLD));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (stall_ev && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (squash_ev && (squash_cnt != '1)) begin
                squash_cnt <= squash_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a per-cycle vector table plus hand-written
// sequences for asynchronous reset in DRAIN and sticky halt.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        IFID_write = 1'b1;
    logic        PC_write = 1'b1;
    logic        halt = 1'b0;
    logic        ihit = 1'b0;
    logic [31:0] imemload = '0;
    logic        iREN;
    logic [31:0] imemaddr;
    logic [31:0] imemload_id;
    logic [31:0] pc_id;
    logic [31:0] pc4_id;
    logic        valid_id;
`ifdef FETCH_STATS_EN
    logic [31:0] stall_cnt;
    logic [31:0] squash_cnt;
`endif

    fetch_stage dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .flush       (flush),
        .redirect_pc (redirect_pc),
        .IFID_write  (IFID_write),
        .PC_write    (PC_write),
        .halt        (halt),
        .ihit        (ihit),
        .imemload    (imemload),
        .iREN        (iREN),
        .imemaddr    (imemaddr),
        .imemload_id (imemload_id),
        .pc_id       (pc_id),
        .pc4_id      (pc4_id),
        .valid_id    (valid_id)
`ifdef FETCH_STATS_EN
        ,
        .stall_cnt   (stall_cnt),
        .squash_cnt  (squash_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        fl;
        logic [31:0] rpc;
        logic        ifw;
        logic        pcw;
        logic        hit;
        logic [31:0] ld;
        logic        e_iren;
        logic [31:0] e_addr;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'hC000_0000 ^ a;
    endfunction

    function automatic vec_t mk(input logic fl, input logic [31:0] rpc, input logic ifw,
                                input logic pcw, input logic hit, input logic [31:0] ld,
                                input logic e_iren, input logic [31:0] e_addr,
                                input logic [31:0] e_instr, input logic [31:0] e_pc,
                                input logic e_valid);
        vec_t v;
        v.fl = fl; v.rpc = rpc; v.ifw = ifw; v.pcw = pcw; v.hit = hit; v.ld = ld;
        v.e_iren = e_iren; v.e_addr = e_addr; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_valid = e_valid;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called just after a rising edge: drive, check the request, then check IF/ID after the edge.
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        flush       = v.fl;
        redirect_pc = v.rpc;
        IFID_write  = v.ifw;
        PC_write    = v.pcw;
        ihit        = v.hit;
        imemload    = v.ld;
        #3;
        check({tag, " iREN"}, 32'(iREN), 32'(v.e_iren));
        check({tag, " imemaddr"}, imemaddr, v.e_addr);
        e.valid = v.e_valid;
        e.instr = v.e_valid ? v.e_instr : NOP;
        e.pc    = v.e_valid ? v.e_pc : 32'h0;
        e.pc4   = v.e_valid ? v.e_pc + 32'd4 : 32'h0;
        sb.push_back(e);
        @(posedge CLK);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, " imemload_id"}, imemload_id, e.instr);
            check({tag, " pc_id"}, pc_id, e.pc);
            check({tag, " pc4_id"}, pc4_id, e.pc4);
            check({tag, " valid_id"}, 32'(valid_id), 32'(e.valid));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " iREN"}, 32'(iREN), 32'h0);
        check({tag, " imemaddr"}, imemaddr, 32'h0);
        check({tag, " imemload_id"}, imemload_id, NOP);
        check({tag, " pc_id"}, pc_id, 32'h0);
        check({tag, " pc4_id"}, pc4_id, 32'h0);
        check({tag, " valid_id"}, 32'(valid_id), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Steady fetch, first cycle after reset has no request
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,            0, 32'h00, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h00),  1, 32'h00, mem(32'h00), 32'h00, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h04),  1, 32'h04, mem(32'h04), 32'h04, 1));
        // Load-use stall at pc 0x8
        vecs.push_back(mk(0, 0, 0, 0, 1, mem(32'h08),  1, 32'h08, mem(32'h04), 32'h04, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,            0, 32'h08, mem(32'h08), 32'h08, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h0C),  1, 32'h0C, mem(32'h0C), 32'h0C, 1));
        // Stall with ihit at 0x10, held two cycles
        vecs.push_back(mk(0, 0, 0, 0, 1, mem(32'h10),  1, 32'h10, mem(32'h0C), 32'h0C, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,            0, 32'h10, mem(32'h0C), 32'h0C, 1));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,            0, 32'h10, mem(32'h10), 32'h10, 1));
        // Flush while fetch in flight -> DRAIN, late ihit discarded
        vecs.push_back(mk(1, 32'h40, 1, 1, 0, 0,       1, 32'h14, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0,            1, 32'h14, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h14),  1, 32'h14, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h40),  1, 32'h40, mem(32'h40), 32'h40, 1));
        // Flush plus stall, misaligned target
        vecs.push_back(mk(1, 32'h103, 0, 0, 1, mem(32'h44), 1, 32'h44, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h100), 1, 32'h100, mem(32'h100), 32'h100, 1));
        // Two flushes during DRAIN: newest target wins
        vecs.push_back(mk(1, 32'h200, 1, 1, 0, 0,      1, 32'h104, NOP, 0, 0));
        vecs.push_back(mk(1, 32'h300, 1, 1, 0, 0,      1, 32'h104, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, 32'hDEAD_BEEF, 1, 32'h104, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h300), 1, 32'h300, mem(32'h300), 32'h300, 1));
        // Flush while in HOLD drops the held word
        vecs.push_back(mk(0, 0, 0, 0, 1, mem(32'h304), 1, 32'h304, mem(32'h300), 32'h300, 1));
        vecs.push_back(mk(1, 32'h80, 1, 1, 0, 0,       0, 32'h304, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h80),  1, 32'h80, mem(32'h80), 32'h80, 1));
        // PC wraps modulo 2^32
        vecs.push_back(mk(1, 32'hFFFF_FFFF, 1, 1, 1, mem(32'h84), 1, 32'h84, NOP, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'hFFFF_FFFC), 1, 32'hFFFF_FFFC,
                          mem(32'hFFFF_FFFC), 32'hFFFF_FFFC, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, mem(32'h00),  1, 32'h00, mem(32'h00), 32'h00, 1));

        repeat (2) @(posedge CLK);
        #1;
        check_reset_outputs("reset");
        nRST = 1'b1;

        foreach (vecs[i]) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // Async reset while in DRAIN
        apply(mk(1, 32'h500, 1, 1, 0, 0, 1, 32'h04, NOP, 0, 0), "drain_enter");
        flush = 1'b0;
        ihit  = 1'b0;
        #1;
        check("drain iREN", 32'(iREN), 32'h1);
        check("drain imemaddr", imemaddr, 32'h04);
        #1;
        nRST = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        apply(mk(0, 0, 1, 1, 0, 0,           0, 32'h00, NOP, 0, 0), "restart0");
        apply(mk(0, 0, 1, 1, 1, mem(32'h00), 1, 32'h00, mem(32'h00), 32'h00, 1), "restart1");

        // Sticky halt: last fetch completes, then no requests even after a redirect
        halt = 1'b1;
        apply(mk(0, 0, 1, 1, 1, mem(32'h04), 1, 32'h04, mem(32'h04), 32'h04, 1), "halt0");
        halt = 1'b0;
        apply(mk(0, 0, 1, 1, 0, 0,           0, 32'h08, mem(32'h04), 32'h04, 1), "halt1");
        apply(mk(1, 32'h500, 1, 1, 0, 0,     0, 32'h08, NOP, 0, 0), "halt2");
        apply(mk(0, 0, 1, 1, 0, 0,           0, 32'h500, NOP, 0, 0), "halt3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
